// File: rtl/sram_responder_if.sv
// Core memory port: the core holds a request until it sees mem_ready; the responder
// answers with extended read data and an error flag.
interface sram_responder_if #(
    parameter int XLEN = 32
);
    logic            mem_wen;
    logic [2:0]      mem_mode;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_dat_o;
    logic [XLEN-1:0] mem_dat_i;
    logic            mem_ready;
    logic            mem_err;

    modport master (
        output mem_wen, mem_mode, mem_addr, mem_dat_o,
        input  mem_dat_i, mem_ready, mem_err
    );

    modport slave (
        input  mem_wen, mem_mode, mem_addr, mem_dat_o,
        output mem_dat_i, mem_ready, mem_err
    );
endinterface

// File: rtl/sram_responder.sv
// Single-port on-chip RAM behind the core memory port, with programmable access latency.
// The port has no strobe, so a new transaction is recognised when the held request changes.
module sram_responder #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic           clk,
    input  logic           rst,
    sram_responder_if.slave bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam int         KEY_W    = 1 + 3 + 2 * XLEN;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [KEY_W-1:0]  key, key_q;
    logic              last_vld_q;
    logic              ready_q;
    logic              err_q;
    logic [XLEN-1:0]   rdata_q;

    logic              is_new;
    logic              capture;
    logic              complete;

    logic [XLEN-1:0]   off;
    logic [AW-1:0]     word_idx;
    logic              is_word;
    logic              is_half;
    logic              misaligned;
    logic              out_of_range;
    logic              acc_err;

    logic [XLEN-1:0]   ram [DEPTH_WORDS];
    logic [XLEN-1:0]   rd_word;
    logic [15:0]       rd_half;
    logic [7:0]        rd_byte;
    logic              sext;
    logic [XLEN-1:0]   rd_ext;

    logic              wr_en;
    logic [3:0]        wr_be;
    logic [XLEN-1:0]   wr_data;

    // Write data only participates in the key for writes, so stray bus data on a read
    // does not look like a new request.
    assign key    = {bus.mem_wen, bus.mem_mode, bus.mem_addr,
                     {XLEN{bus.mem_wen}} & bus.mem_dat_o};
    assign is_new = !last_vld_q || (key != key_q);

    // BASE_ADDR is aligned to the RAM size, so the low offset bits equal the address lane.
    assign off          = bus.mem_addr - BASE_ADDR;
    assign word_idx     = off[AW+1:2];
    assign is_word      = bus.mem_mode[1];
    assign is_half      = !bus.mem_mode[1] && bus.mem_mode[0];
    assign misaligned   = (is_half && off[0]) || (is_word && (off[1:0] != 2'b00));
    assign out_of_range = |off[XLEN-1:AW+2];
    assign acc_err      = misaligned || out_of_range;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise
        // a path that skips the assignment infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        complete = 1'b0;

        if (is_new) begin
            capture = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
        end else begin
            unique case (state_q)
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        complete = 1'b1;
                        state_d  = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples the
        // pre-edge value of every other flop, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_q      <= '0;
            last_vld_q <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                key_q      <= key;
                last_vld_q <= 1'b1;
                ready_q    <= 1'b0;
            end
            if (complete) begin
                ready_q <= 1'b1;
                err_q   <= acc_err;
                rdata_q <= (acc_err || bus.mem_wen) ? '0 : rd_ext;
            end
        end
    end

    assign rd_word = ram[word_idx];

    always_comb begin
        rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte = 8'(rd_word >> {off[1:0], 3'b000});
        sext    = !bus.mem_mode[2];
        if (is_word) begin
            rd_ext = rd_word;
        end else if (is_half) begin
            rd_ext = {{16{sext & rd_half[15]}}, rd_half};
        end else begin
            rd_ext = {{24{sext & rd_byte[7]}}, rd_byte};
        end
    end

    // Narrow stores replicate the low bits onto every lane; the byte enables pick one.
    always_comb begin
        if (is_word) begin
            wr_be   = 4'b1111;
            wr_data = bus.mem_dat_o;
        end else if (is_half) begin
            wr_be   = off[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.mem_dat_o[15:0]}};
        end else begin
            wr_be   = 4'b0001 << off[1:0];
            wr_data = {4{bus.mem_dat_o[7:0]}};
        end
    end

    assign wr_en = complete && bus.mem_wen && !acc_err;

    // NOTE: the RAM array has no reset so it maps onto a plain memory macro; its
    // contents survive a reset pulse and a write is committed only on completion.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) ram[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_dat_i = rdata_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the core's data/instruction port (mem_wen, mem_mode, mem_addr, mem_dat_o, mem_dat_i, mem_ready).
- Single-port on-chip RAM of DEPTH_WORDS 32-bit words with programmable access latency.
- Supports byte, half and word accesses, with load sign/zero-extension and write byte-lane merging.
- The port has no request strobe, so the block detects each new transaction by comparing the held request against the last one it serviced.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- DEPTH_WORDS, 4096, RAM size in 32-bit words; must be a power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
- LATENCY, 1, edges from request sample to mem_ready; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_wen  input  1  1 = write, 0 = read.
- mem_mode  input  3  [1:0] size: 00 byte, 01 half, 10/11 word; [2] = 1 means zero-extend the load.
- mem_addr  input  XLEN  byte address.
- mem_dat_o  input  XLEN  write data from the core, taken from the low bits.
- mem_dat_i  output  XLEN  read data to the core, already extended.
- mem_ready  output  1  response valid; stays high while the same request is held.
- mem_err  output  1  misaligned or out-of-range access; qualified by mem_ready.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: mem_ready=0, mem_dat_i=0, mem_err=0, state=IDLE, last-request-valid=0. RAM contents are not reset.
- Request key: {mem_wen, mem_mode, mem_addr, mem_wen ? mem_dat_o : 0}.
- A request is new when last-request-valid=0 or the key differs from the stored key.
- FSM states IDLE, BUSY, DONE. Counter cnt is 4 bits.
- Any state, new request at edge E0: store key, set last-request-valid=1, mem_ready<=0, cnt<=LATENCY-1, go to BUSY.
- BUSY, key unchanged, cnt!=0: cnt decrements.
- BUSY, key unchanged, cnt==0, at edge E0+LATENCY:
  - perform the access;
  - mem_ready<=1, drive mem_dat_i and mem_err;
  - go to DONE.
- BUSY, key changes before completion: abort, no write is committed, restart on the new key with the full latency.
- DONE, key unchanged: hold mem_ready, mem_dat_i and mem_err. The write is never repeated.
- DONE, key changes: treated as a new request. mem_ready drops on that edge.
- LATENCY=1: request sampled at E0, response visible after E1.
- Decode:
  - word index = (mem_addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2];
  - byte lane = mem_addr[1:0].
- Error conditions:
  - half access with mem_addr[0]=1;
  - word access with mem_addr[1:0]!=0;
  - mem_addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
- On error: mem_err=1, mem_dat_i=0, no RAM write, mem_ready still asserts normally so the core never hangs.
- Read, byte: lane byte, sign-extended unless mode[2]=1.
- Read, half: lane pair {addr[1],0}, sign- or zero-extended the same way.
- Read, word: full word; mode[2] is ignored.
- Write, byte: mem_dat_o[7:0] into lane addr[1:0]; other lanes preserved.
- Write, half: mem_dat_o[15:0] into lanes {addr[1],0}.
- Write, word: all 4 lanes.
- Writes set mem_dat_i=0.
- Read-after-write: a read completing after a write's DONE edge returns the updated data. No bypass is needed because accesses are serialized.
- Back-to-back identical writes are idempotent. The second one, if held with an unchanged key, is not re-detected; this is acceptable.
- Reset asserted mid-BUSY: the pending write is discarded and outputs return to reset values immediately (async).

Test Plan:
- Reset, LATENCY=1: hold read word 0x0, mode 3'b111 → mem_ready rises after the 2nd edge following reset release, mem_dat_i equals the preloaded word, and mem_ready stays high while the request is held.
- Write 0xDEADBEEF word at 0x10, then byte write 0xA5 at 0x11 → word read at 0x10 returns 0xDEADA5EF. LB at 0x11 → 0xFFFFFFA5; LBU at 0x11 → 0x000000A5.
- Half write 0x8001 at 0x22 → LH at 0x22 returns 0xFFFF8001, LHU returns 0x00008001, and lanes 0/1 of word 0x20 are unchanged.
- LATENCY=3: change mem_addr at the 2nd BUSY edge of a pending write → no write is committed to the old address, and ready arrives 3 edges after the change for the new request.
- Misaligned LW at 0x6 and write to BASE_ADDR+4*DEPTH_WORDS → mem_ready=1, mem_err=1, mem_dat_i=0, RAM unchanged on readback.
- Assert rst one edge before completion of a word write to 0x40 → mem_ready=0 immediately, and a later read of 0x40 returns the old value.
